srcnn_mul_arb: RTL

Round-robin arbiter and sequencer that shares one 4-bit × 8-bit unsigned multiplier core among several SRCNN convolution requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, multiplies its operands, and returns the product through a single-entry registered response port tagged with the requester index. It sits between the per-channel MAC sequencers and the shared multiplier resource.

---
 rtl/srcnn_mul_arb_pkg.sv | 15 +
 rtl/srcnn_mul_4ns_8ns_10_1_1.sv | 15 +
 rtl/srcnn_rr_arb.sv | 39 +++
 rtl/srcnn_mul_arb.sv | 135 +++++++++++++
 4 files changed

// File: rtl/srcnn_mul_arb_pkg.sv
// Shared types and default widths for the SRCNN multiplier arbiter.
package srcnn_mul_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int STAT_WIDTH     = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DIN0_WIDTH = 4;
  localparam int DEF_DIN1_WIDTH = 8;
  localparam int DEF_DOUT_WIDTH = 10;

endpackage

// File: rtl/srcnn_mul_4ns_8ns_10_1_1.sv
// Combinational unsigned multiplier core; returns the low dout_WIDTH bits of din0*din1.
module srcnn_mul_4ns_8ns_10_1_1 #(
  parameter int din0_WIDTH = 4,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 10
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Truncating the zero-extended operands first yields the same low bits as the full product.
  assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);

endmodule

// File: rtl/srcnn_rr_arb.sv
// Combinational rotating-priority one-hot selector; search starts at ptr and wraps upward.
module srcnn_rr_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any
);

  logic [ID_WIDTH:0] w_pos;
  logic              w_found;

  always_comb begin
    w_pos     = '0;
    w_found   = 1'b0;
    grant_idx = '0;
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
      if (w_pos >= (ID_WIDTH + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (ID_WIDTH + 1)'(NUM_REQ);
      end
      if (req[w_pos[ID_WIDTH-1:0]]) begin
        w_found   = 1'b1;
        grant_idx = w_pos[ID_WIDTH-1:0];
      end
    end
    any   = w_found & enable;
    grant = '0;
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/srcnn_mul_arb.sv
// Round-robin sharing of one multiplier among NUM_REQ requesters with a one-entry response register.
// Optional per-requester grant counters are enabled by defining SRCNN_MUL_ARB_STATS_EN.
module srcnn_mul_arb
  import srcnn_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DOUT_WIDTH-1:0]         rsp_dout,
  output logic [ID_WIDTH-1:0]           rsp_id
`ifdef SRCNN_MUL_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grants
`endif
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   w_ptr_next;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic [ID_WIDTH-1:0]   r_id;

  logic                  w_can_acc;
  logic                  w_enable;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_gidx;
  logic                  w_any;
  logic [DIN0_WIDTH-1:0] w_a_sel [NUM_REQ];
  logic [DIN1_WIDTH-1:0] w_b_sel [NUM_REQ];
  logic [DIN0_WIDTH-1:0] w_a;
  logic [DIN1_WIDTH-1:0] w_b;
  logic [DOUT_WIDTH-1:0] w_prod;

  assign w_can_acc = (r_state == EMPTY) || rsp_ready;
  assign w_enable  = w_can_acc && !ap_rst;

  srcnn_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .enable    (w_enable),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any       (w_any)
  );

  // One-hot AND-OR operand mux keyed by the grant vector.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opsel
    assign w_a_sel[gi] = w_grant[gi] ? req_din0[gi*DIN0_WIDTH +: DIN0_WIDTH] : '0;
    assign w_b_sel[gi] = w_grant[gi] ? req_din1[gi*DIN1_WIDTH +: DIN1_WIDTH] : '0;
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a = w_a | w_a_sel[i];
      w_b = w_b | w_b_sel[i];
    end
  end

  srcnn_mul_4ns_8ns_10_1_1 #(
    .din0_WIDTH (DIN0_WIDTH),
    .din1_WIDTH (DIN1_WIDTH),
    .dout_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (w_a),
    .din1 (w_b),
    .dout (w_prod)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_any) begin
      w_state_next = FULL;
    end else if ((r_state == FULL) && rsp_ready) begin
      w_state_next = EMPTY;
    end
  end

  assign w_ptr_next = (w_gidx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_dout  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_any) begin
        r_dout <= w_prod;
        r_id   <= w_gidx;
        r_ptr  <= w_ptr_next;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_state == FULL);
  assign rsp_dout  = r_dout;
  assign rsp_id    = r_id;

`ifdef SRCNN_MUL_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_cnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    // Clear wins over a coincident grant; counting stops at all-ones.
    always_ff @(posedge ap_clk) begin
      if (ap_rst || stat_clr) begin
        r_stat_cnt[gi] <= '0;
      end else if (w_grant[gi] && (r_stat_cnt[gi] != '1)) begin
        r_stat_cnt[gi] <= r_stat_cnt[gi] + 1'b1;
      end
    end
    assign stat_grants[gi*STAT_WIDTH +: STAT_WIDTH] = r_stat_cnt[gi];
  end
`endif

endmodule
